// File: rtl/bit_serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU.
//   OP_*     : operation encodings carried on the 2-bit op bus
//   state_e  : control FSM states (idle, shifting bits, result pulse)
package bit_serial_alu_pkg;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_ADD  = 2'd2;
  localparam logic [1:0] OP_ZERO = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/alu_slice.sv
// One-bit combinational ALU slice used by the bit-serial datapath.
// Ports:
//   a, b  : operand bits for the current position
//   cin   : carry from the previous (less significant) bit
//   binv  : invert b before the adder (subtract); only meaningful with OP_ADD
//   op    : operation select (OP_AND, OP_OR, OP_ADD, OP_ZERO)
//   r     : result bit
//   cout  : carry out of this bit position (0 for non-add ops)
module alu_slice
  import bit_serial_alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       binv,
  input  logic [1:0] op,
  output logic       r,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    b_eff = b ^ binv;
    r     = 1'b0;
    cout  = 1'b0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD: begin
        r    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      OP_ZERO: r = 1'b0;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: processes one operand bit per clock, LSB first.
// An accepted start captures the operands, WIDTH RUN cycles shift the slice
// result into r from the MSB side, then a single DONE cycle pulses done.
// Optional feature: define BIT_SERIAL_ALU_OVF_EN to add the ovf output
// (signed overflow of the add/subtract).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin an operation (sampled only while idle)
//   a, b         : operands, captured on accepted start
//   op, binv     : operation select; binv with op=ADD selects a-b
//   busy, done   : busy in RUN/DONE; done is a one-cycle result pulse
//   r, cout, zero: result, final carry (add/sub only), r==0 flag
//   ovf          : signed overflow (only with BIT_SERIAL_ALU_OVF_EN)
module bit_serial_alu
  import bit_serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             binv,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             zero
`ifdef BIT_SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [1:0]       op_q;
  logic             binv_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             cout_q;
  logic             zero_q;

  logic             slice_r;
  logic             slice_cout;
  logic [WIDTH-1:0] r_shift;
  logic             last_bit;
  logic             sub_sel;

  // Subtract is only honoured for the add op; elsewhere binv is a don't-care.
  assign sub_sel  = binv & (op == OP_ADD);
  assign last_bit = (cnt_q == LastBit);
  assign r_shift  = {slice_r, r_q[WIDTH-1:1]};

  alu_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .binv (binv_q),
    .op   (op_q),
    .r    (slice_r),
    .cout (slice_cout)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (last_bit) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StRun:  busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      binv_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            binv_q  <= sub_sel;
            // Two's complement subtract: inverted B plus an initial carry of 1.
            carry_q <= sub_sel;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          r_q     <= r_shift;
          carry_q <= slice_cout;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            cout_q <= (op_q == OP_ADD) & slice_cout;
            zero_q <= (r_shift == '0);
          end
        end
        StDone: begin
          // Result registers already final; hold.
        end
        default: begin
        end
      endcase
    end
  end

  assign r    = r_q;
  assign cout = cout_q;
  assign zero = zero_q;

`ifdef BIT_SERIAL_ALU_OVF_EN
  logic ovf_q;

  // On the MSB cycle carry_q is the carry into the MSB and slice_cout the
  // carry out; their XOR is the signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && last_bit) begin
      ovf_q <= (op_q == OP_ADD) & (carry_q ^ slice_cout);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
module tb_bit_serial_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic [1:0]   op;
  logic         binv;
  logic         busy, done;
  logic [W-1:0] r;
  logic         cout, zero;
`ifdef BIT_SERIAL_ALU_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .op    (op),
    .binv  (binv),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .cout  (cout),
    .zero  (zero)
`ifdef BIT_SERIAL_ALU_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic model(input int ma, input int mb, input int mop, input bit mbinv,
                       output int er, output int ec, output int eo);
    int s;
    int mod;
    mod = 1 << W;
    er = 0; ec = 0; eo = 0;
    case (mop)
      0: er = ma & mb;
      1: er = ma | mb;
      2: begin
        if (mbinv) begin
          s  = ma - mb;
          ec = (ma >= mb) ? 1 : 0;
          // signed interpretation
          s  = ((ma >= mod / 2) ? ma - mod : ma) - ((mb >= mod / 2) ? mb - mod : mb);
          er = (ma - mb + mod) % mod;
        end else begin
          er = (ma + mb) % mod;
          ec = (ma + mb >= mod) ? 1 : 0;
          s  = ((ma >= mod / 2) ? ma - mod : ma) + ((mb >= mod / 2) ? mb - mod : mb);
        end
        eo = (s < -(mod / 2) || s > mod / 2 - 1) ? 1 : 0;
      end
      default: er = 0;
    endcase
  endtask

  // Called just after the accept edge; returns edges counted up to done.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!done && cycles < W + 6) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Runs one operation; optionally pulses start with other operands mid-RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top,
                        input logic tbinv, input bit poke);
    int er, ec, eo, cyc;
    model(int'(ta), int'(tb), int'(top), tbinv, er, ec, eo);
    @(negedge clk);
    a = ta; b = tb; op = top; binv = tbinv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_run", busy, 1);
    cyc = 1;
    if (poke) begin
      @(negedge clk); cyc++;
      @(negedge clk); cyc++;
      a = ~ta; b = ta ^ 8'h5a; op = 2'd1; binv = 1'b0; start = 1'b1;
      @(negedge clk); cyc++;
      start = 1'b0;
    end
    while (!done && cyc < W + 6) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, W + 1);
    check("r", r, er);
    check("cout", cout, ec);
    check("zero", zero, (er == 0) ? 1 : 0);
`ifdef BIT_SERIAL_ALU_OVF_EN
    check("ovf", ovf, eo);
`endif
    a = ~ta; b = ~tb;
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_idle", busy, 0);
    @(negedge clk);
    check("r_hold", r, er);
    check("done_low", done, 0);
  endtask

  initial begin
    int cyc, er, ec, eo;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0; binv = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_r", r, 0);
    check("rst_cout", cout, 0);
    check("rst_zero", zero, 1);
    rst = 1'b0;

    // Directed scenarios
    run_op(8'h0F, 8'h01, 2'd2, 1'b0, 0);
    run_op(8'h05, 8'h05, 2'd2, 1'b1, 0);
    run_op(8'h03, 8'h05, 2'd2, 1'b1, 0);
    run_op(8'hF0, 8'h3C, 2'd0, 1'b0, 0);
    run_op(8'hF0, 8'h3C, 2'd1, 1'b0, 0);
    run_op(8'hF0, 8'h3C, 2'd3, 1'b0, 0);
    run_op(8'hFF, 8'h01, 2'd2, 1'b0, 0);
    run_op(8'hF0, 8'h3C, 2'd0, 1'b1, 0);
`ifdef BIT_SERIAL_ALU_OVF_EN
    run_op(8'h7F, 8'h01, 2'd2, 1'b0, 0);
    check("ovf_7f", ovf, 1);
    run_op(8'h01, 8'h01, 2'd2, 1'b0, 0);
    check("ovf_01", ovf, 0);
`endif

    // start during RUN is ignored
    run_op(8'h21, 8'h13, 2'd2, 1'b0, 1);

    // Reset 4 cycles into RUN aborts with no done pulse
    @(negedge clk);
    a = 8'h44; b = 8'h22; op = 2'd2; binv = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_r", r, 0);
    check("abort_cout", cout, 0);
    check("abort_zero", zero, 1);
    cyc = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) cyc++;
    end
    check("abort_no_done", cyc, 0);
    run_op(8'h44, 8'h22, 2'd2, 1'b0, 0);

    // start held through DONE is taken only after returning to IDLE
    @(negedge clk);
    a = 8'h10; b = 8'h20; op = 2'd2; binv = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("b2b_lat1", cyc, W + 1);
    a = 8'h9C; b = 8'h1D; op = 2'd2; binv = 1'b1; start = 1'b1;
    @(negedge clk);
    check("b2b_idle", busy, 0);
    check("b2b_r_first", r, 8'h30);
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept", busy, 1);
    wait_done(cyc);
    model(8'h9C, 8'h1D, 2, 1'b1, er, ec, eo);
    check("b2b_lat2", cyc, W + 1);
    check("b2b_r", r, er);
    check("b2b_cout", cout, ec);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port: op  input  2  0=AND, 1=OR, 2=ADD/SUB, 3=zero result.
REQ-008 SHALL have port: binv  input  1  with op=2: 1 selects subtract (A-B); ignored otherwise.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-011 SHALL have port: r  output  WIDTH  result; held stable from done until the next accepted start.
REQ-012 SHALL have port: cout  output  1  final carry out of the MSB for op=2; 0 for other ops.
REQ-013 SHALL have port: zero  output  1  high when r equals 0; valid alongside r.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE, start=1 SHALL capture a, b, op and binv, clear the bit counter, and move to RUN on the same edge.
REQ-016 If op=2 and binv=1, the carry flop SHALL load 1 and every B bit SHALL be inverted; otherwise the carry SHALL load 0.
REQ-017 In RUN, one bit per cycle SHALL be processed LSB first: the slice output is shifted into r from the MSB side, and the carry flop is updated.
REQ-018 RUN SHALL last exactly WIDTH cycles; after the bit with index WIDTH-1, the FSM SHALL enter DONE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE; total latency from the accepted-start edge to done is WIDTH+1 cycles.
REQ-020 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored with no effect on state or result.
REQ-022 start asserted in the same cycle the FSM returns to IDLE SHALL be accepted on the next edge (no back-to-back acceptance from DONE).
REQ-023 cout SHALL equal the carry flop after the MSB is processed for op=2, and SHALL be forced to 0 for ops 0, 1 and 3.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; subtract SHALL use two's complement, so cout=1 means no borrow.
REQ-025 r, cout and zero SHALL update only during RUN/DONE and hold their values in IDLE.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, r=0, cout=0, zero=1, counter=0, carry=0, on the next clock edge.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; the partial result SHALL be discarded.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro BIT_SERIAL_ALU_OVF_EN: when defined, the block SHALL add output ovf (1 bit), the signed overflow for op=2 (carry into MSB XOR carry out of MSB), with reset value 0 and held like r.
REQ-030 When the macro is undefined, the ovf port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 Shared package bit_serial_alu_pkg SHALL hold the op encoding constants (OP_AND, OP_OR, OP_ADD, OP_ZERO) and the FSM state typedef.
REQ-032 The per-bit datapath SHALL be one combinational sub-module, alu_slice: inputs a, b, cin, binv, op; outputs r, cout.

Verification (WIDTH=8)
REQ-033 Scenario: op=2, binv=0, a=0x0F, b=0x01, start -> done exactly 9 cycles later, r=0x10, cout=0, zero=0.
REQ-034 Scenario: op=2, binv=1, a=0x05, b=0x05 -> r=0x00, cout=1, zero=1; second case a=0x03, b=0x05 -> r=0xFE, cout=0.
REQ-035 Scenario: op=0 with a=0xF0, b=0x3C -> r=0x30; op=1 with the same operands -> r=0xFC; op=3 -> r=0x00, zero=1; cout=0 in all three cases.
REQ-036 Scenario: start pulsed during RUN with different operands -> ignored; the original result is delivered and exactly one done pulse occurs.
REQ-037 Scenario: rst asserted 4 cycles into RUN -> no done pulse, r=0, busy=0 next cycle; a new start then completes normally.
REQ-038 Scenario (macro defined): op=2, a=0x7F, b=0x01 -> r=0x80, ovf=1, cout=0; a=0x01, b=0x01 -> ovf=0.
